// File: rtl/ps2_keyboard.sv
// PS/2 keyboard receiver and scan-code decoder feeding the Hack keyboard register.
// Define PS2_PARITY_CHECK_EN to drop bytes whose parity bit is wrong.
`timescale 1ns/1ps

module ps2_keyboard #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [15:0] key,
    output logic        key_valid,
    output logic        frame_err
);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_t;

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    rx_state_t     state, state_nxt;
    logic          clk_s1, clk_s2, clk_prev, dat_s1, dat_s2;
    logic          fall, timeout, stop_ok, parity_ok;
    logic          rdy_set, err_set, shift_en, par_en, start_en;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          par_bit;
    logic [TW-1:0] to_cnt;
    logic          byte_rdy;
    logic          ext, brk, shift;
    logic [8:0]    last_scan;
    logic          ext_n, brk_n, shift_n;
    logic [8:0]    last_n;
    logic [15:0]   key_n;
    logic [16:0]   mapped;

    // Synchronizers reset to the idle-high line level so reset never fakes an edge.
    always_ff @(posedge CLK) begin
        if (reset) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            clk_prev <= 1'b1;
            dat_s1   <= 1'b1;
            dat_s2   <= 1'b1;
        end else begin
            clk_s1   <= ps2_clk;
            clk_s2   <= clk_s1;
            clk_prev <= clk_s2;
            dat_s1   <= ps2_data;
            dat_s2   <= dat_s1;
        end
    end

    assign fall    = clk_prev & ~clk_s2;
    assign timeout = (state != IDLE) && !fall && (to_cnt == TO_LAST);

`ifdef PS2_PARITY_CHECK_EN
    assign parity_ok = ^{shreg, par_bit};
`else
    // Parity is captured but deliberately ignored in this build.
    assign parity_ok = par_bit | 1'b1;
`endif
    assign stop_ok = dat_s2 & parity_ok;

    always_ff @(posedge CLK) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (timeout) begin
            state_nxt = IDLE;
        end else if (fall) begin
            case (state)
                IDLE:    if (!dat_s2) state_nxt = DATA;
                DATA:    if (bit_cnt == 3'd7) state_nxt = PARITY;
                PARITY:  state_nxt = STOP;
                STOP:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        start_en = (state == IDLE) && fall && !dat_s2;
        shift_en = (state == DATA) && fall;
        par_en   = (state == PARITY) && fall;
        rdy_set  = (state == STOP) && fall && stop_ok;
        err_set  = ((state == STOP) && fall && !stop_ok) || timeout;
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            bit_cnt   <= '0;
            shreg     <= '0;
            par_bit   <= 1'b0;
            to_cnt    <= '0;
            byte_rdy  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (start_en) bit_cnt <= '0;
            else if (shift_en) bit_cnt <= bit_cnt + 3'd1;
            if (shift_en) shreg <= {dat_s2, shreg[7:1]};
            if (par_en) par_bit <= dat_s2;
            if (state == IDLE || fall || timeout) to_cnt <= '0;
            else to_cnt <= to_cnt + TW'(1);
            byte_rdy  <= rdy_set;
            frame_err <= err_set;
        end
    end

    // Returns {hit, hack_code}; only the four arrow keys are recognised after E0.
    function automatic logic [16:0] map_code(input logic e, input logic [7:0] c, input logic sh);
        logic [16:0] r;
        r = '0;
        if (e) begin
            case (c)
                8'h6B: r = {1'b1, 16'd130};
                8'h75: r = {1'b1, 16'd131};
                8'h74: r = {1'b1, 16'd132};
                8'h72: r = {1'b1, 16'd133};
                default: r = '0;
            endcase
        end else begin
            case (c)
                8'h1C: r = {1'b1, 16'd65};  8'h32: r = {1'b1, 16'd66};
                8'h21: r = {1'b1, 16'd67};  8'h23: r = {1'b1, 16'd68};
                8'h24: r = {1'b1, 16'd69};  8'h2B: r = {1'b1, 16'd70};
                8'h34: r = {1'b1, 16'd71};  8'h33: r = {1'b1, 16'd72};
                8'h43: r = {1'b1, 16'd73};  8'h3B: r = {1'b1, 16'd74};
                8'h42: r = {1'b1, 16'd75};  8'h4B: r = {1'b1, 16'd76};
                8'h3A: r = {1'b1, 16'd77};  8'h31: r = {1'b1, 16'd78};
                8'h44: r = {1'b1, 16'd79};  8'h4D: r = {1'b1, 16'd80};
                8'h15: r = {1'b1, 16'd81};  8'h2D: r = {1'b1, 16'd82};
                8'h1B: r = {1'b1, 16'd83};  8'h2C: r = {1'b1, 16'd84};
                8'h3C: r = {1'b1, 16'd85};  8'h2A: r = {1'b1, 16'd86};
                8'h1D: r = {1'b1, 16'd87};  8'h22: r = {1'b1, 16'd88};
                8'h35: r = {1'b1, 16'd89};  8'h1A: r = {1'b1, 16'd90};
                8'h45: r = {1'b1, sh ? 16'd41 : 16'd48};
                8'h16: r = {1'b1, sh ? 16'd33 : 16'd49};
                8'h1E: r = {1'b1, sh ? 16'd64 : 16'd50};
                8'h26: r = {1'b1, sh ? 16'd35 : 16'd51};
                8'h25: r = {1'b1, sh ? 16'd36 : 16'd52};
                8'h2E: r = {1'b1, sh ? 16'd37 : 16'd53};
                8'h36: r = {1'b1, sh ? 16'd94 : 16'd54};
                8'h3D: r = {1'b1, sh ? 16'd38 : 16'd55};
                8'h3E: r = {1'b1, sh ? 16'd42 : 16'd56};
                8'h46: r = {1'b1, sh ? 16'd40 : 16'd57};
                8'h29: r = {1'b1, 16'd32};
                8'h5A: r = {1'b1, 16'd128};
                8'h66: r = {1'b1, 16'd129};
                8'h76: r = {1'b1, 16'd140};
                default: r = '0;
            endcase
        end
        return r;
    endfunction

    assign mapped = map_code(ext, shreg, shift);

    // Prefix bytes only set flags; any other byte consumes and clears them.
    always_comb begin
        ext_n   = ext;
        brk_n   = brk;
        shift_n = shift;
        key_n   = key;
        last_n  = last_scan;
        if (byte_rdy) begin
            if (shreg == 8'hE0) begin
                ext_n = 1'b1;
            end else if (shreg == 8'hF0) begin
                brk_n = 1'b1;
            end else begin
                ext_n = 1'b0;
                brk_n = 1'b0;
                if (!ext && (shreg == 8'h12 || shreg == 8'h59)) begin
                    shift_n = !brk;
                end else if (brk) begin
                    if ({ext, shreg} == last_scan) key_n = '0;
                end else if (mapped[16]) begin
                    key_n  = mapped[15:0];
                    last_n = {ext, shreg};
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            ext       <= 1'b0;
            brk       <= 1'b0;
            shift     <= 1'b0;
            last_scan <= '0;
            key       <= '0;
            key_valid <= 1'b0;
        end else begin
            ext       <= ext_n;
            brk       <= brk_n;
            shift     <= shift_n;
            last_scan <= last_n;
            key       <= key_n;
            key_valid <= (key_n != key);
        end
    end

endmodule

// File: tb/tb_ps2_keyboard.sv
// Randomised scoreboard bench for ps2_keyboard: a scan-code model predicts every key change,
// a monitor pops and compares on each key_valid pulse.
`timescale 1ns/1ps

module tb_ps2_keyboard;

    localparam int TO   = 300;
    localparam int HALF = 6;
    localparam int GAP  = 16;

    localparam logic [7:0] LETTERS [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
        8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B,
        8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    localparam logic [7:0] DIGITS [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36,
        8'h3D, 8'h3E, 8'h46};
    localparam logic [7:0] ARROWS [4] = '{8'h6B, 8'h75, 8'h74, 8'h72};

    logic        CLK = 1'b0;
    logic        reset = 1'b1;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic [15:0] key;
    logic        key_valid;
    logic        frame_err;

    int passCount = 0;
    int checkCount = 0;
    int errSeen = 0;
    int errExp = 0;
    logic [15:0] expQ[$];

    int mKey = 0;
    bit mExt = 0, mBrk = 0, mShift = 0;
    int mLast = -1;

    int poolCode[$];
    bit poolExt[$];

    ps2_keyboard #(.TIMEOUT_CYCLES(TO)) dut (
        .CLK(CLK), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .key(key), .key_valid(key_valid), .frame_err(frame_err)
    );

    always #5 CLK = ~CLK;

    function automatic int lookup(bit e, logic [7:0] c, bit sh);
        string sym;
        sym = ")!@#$%^&*(";
        if (e) begin
            for (int i = 0; i < 4; i++) if (ARROWS[i] == c) return 130 + i;
            return -1;
        end
        for (int i = 0; i < 26; i++) if (LETTERS[i] == c) return 65 + i;
        for (int i = 0; i < 10; i++) if (DIGITS[i] == c) return sh ? int'(sym[i]) : 48 + i;
        if (c == 8'h29) return 32;
        if (c == 8'h5A) return 128;
        if (c == 8'h66) return 129;
        if (c == 8'h76) return 140;
        return -1;
    endfunction

    task automatic modelByte(input logic [7:0] b);
        int newKey;
        int v;
        int scan;
        newKey = mKey;
        if (b == 8'hE0) mExt = 1;
        else if (b == 8'hF0) mBrk = 1;
        else begin
            v = lookup(mExt, b, mShift);
            scan = (mExt ? 256 : 0) + int'(b);
            if (!mExt && (b == 8'h12 || b == 8'h59)) mShift = !mBrk;
            else if (mBrk) begin
                if (scan == mLast) newKey = 0;
            end else if (v >= 0) begin
                newKey = v;
                mLast = scan;
            end
            mExt = 0;
            mBrk = 0;
        end
        if (newKey != mKey) begin
            expQ.push_back(16'(newKey));
            mKey = newKey;
        end
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        checkCount++;
        if (actual == expected) passCount++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    task automatic sendBit(input bit d);
        @(posedge CLK); #1 ps2_data = d;
        repeat (HALF) @(posedge CLK);
        #1 ps2_clk = 1'b0;
        repeat (HALF) @(posedge CLK);
        #1 ps2_clk = 1'b1;
    endtask

    task automatic sendFrame(input logic [7:0] b, input bit badPar, input bit badStop);
        sendBit(1'b0);
        for (int i = 0; i < 8; i++) sendBit(b[i]);
        sendBit((~^b) ^ badPar);
        sendBit(!badStop);
        @(posedge CLK); #1 ps2_data = 1'b1;
        repeat (GAP) @(posedge CLK);
    endtask

    task automatic sendPartial(input int n);
        sendBit(1'b0);
        for (int i = 0; i < n; i++) sendBit(1'($urandom_range(0, 1)));
        @(posedge CLK); #1 ps2_data = 1'b1;
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        modelByte(b);
        sendFrame(b, 1'b0, 1'b0);
    endtask

    task automatic sendBadStop(input logic [7:0] b);
        errExp++;
        sendFrame(b, 1'b0, 1'b1);
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while (expQ.size() != 0 && n < 200) begin
            @(posedge CLK);
            n++;
        end
        if (expQ.size() != 0) checkOutput("drain_timeout", expQ.size(), 0);
        repeat (8) @(posedge CLK);
    endtask

    task automatic checkpoint(input string name, input int expKey);
        waitDrain();
        @(negedge CLK);
        checkOutput({name, "_key"}, int'(key), expKey);
        checkOutput({name, "_errs"}, errSeen, errExp);
    endtask

    task automatic doReset();
        @(posedge CLK); #1 reset = 1'b1;
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        checkOutput("reset_key", int'(key), 0);
        checkOutput("reset_key_valid", int'(key_valid), 0);
        checkOutput("reset_frame_err", int'(frame_err), 0);
        expQ.delete();
        mKey = 0; mExt = 0; mBrk = 0; mShift = 0; mLast = -1;
        @(posedge CLK); #1 reset = 1'b0;
        repeat (4) @(posedge CLK);
    endtask

    // Monitor: every key_valid pulse must match the next predicted key and every
    // change of key must carry a pulse.
    initial begin
        logic [15:0] prevKey;
        logic [15:0] expKey;
        prevKey = '0;
        forever begin
            @(negedge CLK);
            if (reset) begin
                prevKey = key;
            end else begin
                if (frame_err) errSeen++;
                if (key_valid) begin
                    if (expQ.size() == 0) begin
                        checkCount++;
                        $display("[TB] FAIL valid_unexpected: key_valid with key=%0d, no change predicted", key);
                    end else begin
                        expKey = expQ.pop_front();
                        checkOutput("sb_key", int'(key), int'(expKey));
                    end
                    checkOutput("valid_marks_change", int'(key != prevKey), 1);
                end else if (key != prevKey) begin
                    checkCount++;
                    $display("[TB] FAIL key_silent_change: key=%0d was %0d without key_valid", key, prevKey);
                end
                prevKey = key;
            end
        end
    end

    initial begin
        #5ms;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $display("%0d/%0d checks passed", passCount, checkCount + 1);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        for (int i = 0; i < 26; i++) begin poolCode.push_back(LETTERS[i]); poolExt.push_back(0); end
        for (int i = 0; i < 10; i++) begin poolCode.push_back(DIGITS[i]); poolExt.push_back(0); end
        for (int i = 0; i < 4; i++) begin poolCode.push_back(ARROWS[i]); poolExt.push_back(1); end
        foreach (poolCode[i]) ;
        poolCode.push_back(8'h29); poolExt.push_back(0);
        poolCode.push_back(8'h5A); poolExt.push_back(0);
        poolCode.push_back(8'h66); poolExt.push_back(0);
        poolCode.push_back(8'h76); poolExt.push_back(0);
        poolCode.push_back(8'h12); poolExt.push_back(0);
        poolCode.push_back(8'h59); poolExt.push_back(0);
        poolCode.push_back(8'h12); poolExt.push_back(0);
        poolCode.push_back(8'h05); poolExt.push_back(0);
        poolCode.push_back(8'h0D); poolExt.push_back(0);
        poolCode.push_back(8'h14); poolExt.push_back(0);
        poolCode.push_back(8'h1F); poolExt.push_back(1);

        doReset();

        // E0 prefix and partial frame lost across a mid-frame reset.
        applyStimulus(8'hE0);
        sendPartial(4);
        doReset();
        applyStimulus(8'h75);
        checkpoint("after_midreset", 0);

        applyStimulus(8'h1C);
        checkpoint("make_a", 65);
        applyStimulus(8'hF0); applyStimulus(8'h1C);
        checkpoint("break_a", 0);

        applyStimulus(8'hE0); applyStimulus(8'h75);
        checkpoint("make_up", 131);
        applyStimulus(8'hF0); applyStimulus(8'h1C);
        checkpoint("foreign_break", 131);
        applyStimulus(8'hE0); applyStimulus(8'hF0); applyStimulus(8'h75);
        checkpoint("break_up", 0);

        applyStimulus(8'h12); applyStimulus(8'h16);
        checkpoint("shift_1", 33);
        applyStimulus(8'h16);
        checkpoint("repeat_1", 33);
        applyStimulus(8'hF0); applyStimulus(8'h16);
        checkpoint("break_1", 0);
        applyStimulus(8'hF0); applyStimulus(8'h12);
        applyStimulus(8'h16);
        checkpoint("unshift_1", 49);
        applyStimulus(8'hF0); applyStimulus(8'h16);
        checkpoint("break_1b", 0);

`ifdef PS2_PARITY_CHECK_EN
        errExp++;
        sendFrame(8'h1C, 1'b1, 1'b0);
        checkpoint("bad_parity", 0);
`else
        modelByte(8'h1C);
        sendFrame(8'h1C, 1'b1, 1'b0);
        checkpoint("bad_parity", 65);
        applyStimulus(8'hF0); applyStimulus(8'h1C);
        checkpoint("bad_parity_release", 0);
`endif

        sendPartial(3);
        errExp++;
        repeat (TO + 10) @(posedge CLK);
        checkpoint("timeout", 0);
        applyStimulus(8'h29);
        checkpoint("recover_space", 32);

        sendBadStop(8'h1C);
        checkpoint("bad_stop", 32);
        applyStimulus(8'hF0); applyStimulus(8'h29);
        checkpoint("break_space", 0);

        for (int n = 0; n < 60; n++) begin
            int idx;
            bit isBreak;
            idx = $urandom_range(0, poolCode.size() - 1);
            isBreak = ($urandom_range(0, 9) < 4);
            if (poolExt[idx]) applyStimulus(8'hE0);
            if (isBreak) applyStimulus(8'hF0);
            applyStimulus(8'(poolCode[idx]));
            if ($urandom_range(0, 9) == 0) sendBadStop(8'($urandom_range(0, 255)));
            if (n % 10 == 9) checkpoint("random", mKey);
        end

        checkpoint("final", mKey);
        checkOutput("final_queue_empty", expQ.size(), 0);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
